// File: rtl/fbw_pkg.sv
// Shared types and constants for the frame burst writer: FSM state encoding,
// MCB command opcodes and the byte-address helper.
package fbw_pkg;

    typedef enum logic [1:0] {
        StCalib,
        StIdle,
        StFill,
        StCmd
    } fbw_state_e;

    localparam logic [2:0] McbInstrWrite = 3'b000;

    // Word pointer to byte address; wraps modulo 2^30.
    function automatic logic [29:0] word_addr(input logic [29:0] base, input logic [29:0] ptr);
        return base + (ptr << 2);
    endfunction

endpackage

// File: rtl/fbw_sync2.sv
// Two-flop synchroniser for a single quasi-static level (mem_calib_done).
module fbw_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/frame_burst_writer.sv
// Streams engine words into MCB write bursts, double-buffering frames in memory.
// Define FBW_STATS_EN to add the frame_count / burst_count status outputs.
module frame_burst_writer
    import fbw_pkg::*;
#(
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned FRAME_WORDS = 4096,
    parameter logic [29:0] BUF0_BASE   = 30'h0000000,
    parameter logic [29:0] BUF1_BASE   = 30'h0100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        src_valid,
    input  logic [31:0] src_data,
    output logic        src_ready,
    input  logic        frame_done,
    input  logic        render_reset,
    input  logic        mem_calib_done,
    input  logic        mem_wr_full,
    input  logic        mem_wr_empty,
    input  logic        mem_cmd_full,
    output logic        mem_reset,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data,
    output logic        mem_cmd_en,
    output logic [2:0]  mem_cmd_instr,
    output logic [5:0]  mem_cmd_bl,
    output logic [29:0] mem_cmd_byte_addr,
    output logic        display_buf,
    output logic        clear_frame,
    output logic        busy
`ifdef FBW_STATS_EN
    ,
    output logic [15:0] frame_count,
    output logic [23:0] burst_count
`endif
);

    localparam int unsigned PtrW = $clog2(FRAME_WORDS + 1);
    localparam logic [PtrW-1:0] FrameWordsP = PtrW'(FRAME_WORDS);
    localparam logic [PtrW-1:0] BurstP      = PtrW'(BURST_LEN);
    localparam logic [6:0]      BeatLast    = 7'(BURST_LEN - 1);
    localparam logic [5:0]      CmdBl       = 6'(BURST_LEN - 1);

    fbw_state_e      state_q, state_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [6:0]      beat_q, beat_d;
    logic            active_q, active_d;
    logic            disp_q, disp_d;
    logic            pend_fd_q, pend_fd_d;
    logic            pend_rr_q, pend_rr_d;
    logic            mem_reset_q;
    logic            calib_sync;
    logic            eff_fd, eff_rr;
    logic            apply_fd, apply_rr;
    logic            accept;

    fbw_sync2 u_calib_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (mem_calib_done),
        .q_o     (calib_sync)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StCalib;
            ptr_q       <= '0;
            beat_q      <= '0;
            active_q    <= 1'b0;
            disp_q      <= 1'b0;
            pend_fd_q   <= 1'b0;
            pend_rr_q   <= 1'b0;
            mem_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            beat_q      <= beat_d;
            active_q    <= active_d;
            disp_q      <= disp_d;
            pend_fd_q   <= pend_fd_d;
            pend_rr_q   <= pend_rr_d;
            mem_reset_q <= 1'b0;
        end
    end

    always_comb begin
        state_d           = state_q;
        ptr_d             = ptr_q;
        beat_d            = beat_q;
        active_d          = active_q;
        disp_d            = disp_q;
        src_ready         = 1'b0;
        mem_wr_en         = 1'b0;
        mem_wr_data       = '0;
        mem_cmd_en        = 1'b0;
        mem_cmd_bl        = '0;
        mem_cmd_byte_addr = '0;
        accept            = 1'b0;

        // Pulses are held until the FSM is back in IDLE; render_reset dominates.
        eff_fd    = pend_fd_q | frame_done;
        eff_rr    = pend_rr_q | render_reset;
        apply_rr  = (state_q == StIdle) && eff_rr;
        apply_fd  = (state_q == StIdle) && eff_fd && !eff_rr;
        pend_fd_d = eff_fd;
        pend_rr_d = eff_rr;

        unique case (state_q)
            StCalib: begin
                if (calib_sync) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (apply_rr || apply_fd) begin
                    ptr_d     = '0;
                    pend_fd_d = 1'b0;
                    pend_rr_d = 1'b0;
                    if (apply_fd) begin
                        disp_d   = active_q;
                        active_d = ~active_q;
                    end
                end else if (mem_wr_empty && src_valid && (ptr_q < FrameWordsP)) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                src_ready = ~mem_wr_full;
                accept    = src_valid & ~mem_wr_full;
                if (accept) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_data = src_data;
                    if (beat_q == BeatLast) begin
                        beat_d  = '0;
                        state_d = StCmd;
                    end else begin
                        beat_d = beat_q + 7'd1;
                    end
                end
            end
            StCmd: begin
                if (!mem_cmd_full) begin
                    mem_cmd_en        = 1'b1;
                    mem_cmd_bl        = CmdBl;
                    mem_cmd_byte_addr = word_addr(active_q ? BUF1_BASE : BUF0_BASE, 30'(ptr_q));
                    ptr_d             = ptr_q + BurstP;
                    state_d           = StIdle;
                end
            end
            default: state_d = StCalib;
        endcase
    end

    assign mem_reset     = mem_reset_q;
    assign mem_cmd_instr = McbInstrWrite;
    assign display_buf   = disp_q;
    assign clear_frame   = (ptr_q == '0);
    assign busy          = (state_q != StIdle);

`ifdef FBW_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [23:0] burst_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
            burst_cnt_q <= '0;
        end else begin
            if (apply_fd) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (apply_rr) begin
                burst_cnt_q <= '0;
            end else if (mem_cmd_en) begin
                burst_cnt_q <= burst_cnt_q + 24'd1;
            end
        end
    end

    assign frame_count = frame_cnt_q;
    assign burst_count = burst_cnt_q;
`endif

endmodule

// File: tb/tb_frame_burst_writer.sv
// Randomised bench for frame_burst_writer against a word/burst/frame level model,
// with directed calibration, burst, backpressure, frame-swap, collision and reset phases.
module tb_frame_burst_writer;

    localparam int unsigned BL = 4;
    localparam int unsigned FW = 8;
    localparam logic [29:0] B0 = 30'h0000040;
    localparam logic [29:0] B1 = 30'h0100000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        src_valid;
    logic [31:0] src_data;
    logic        src_ready;
    logic        frame_done;
    logic        render_reset;
    logic        mem_calib_done;
    logic        mem_wr_full;
    logic        mem_wr_empty;
    logic        mem_cmd_full;
    logic        mem_reset;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic        mem_cmd_en;
    logic [2:0]  mem_cmd_instr;
    logic [5:0]  mem_cmd_bl;
    logic [29:0] mem_cmd_byte_addr;
    logic        display_buf;
    logic        clear_frame;
    logic        busy;
`ifdef FBW_STATS_EN
    logic [15:0] frame_count;
    logic [23:0] burst_count;
`endif

    frame_burst_writer #(
        .BURST_LEN   (BL),
        .FRAME_WORDS (FW),
        .BUF0_BASE   (B0),
        .BUF1_BASE   (B1)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .src_valid         (src_valid),
        .src_data          (src_data),
        .src_ready         (src_ready),
        .frame_done        (frame_done),
        .render_reset      (render_reset),
        .mem_calib_done    (mem_calib_done),
        .mem_wr_full       (mem_wr_full),
        .mem_wr_empty      (mem_wr_empty),
        .mem_cmd_full      (mem_cmd_full),
        .mem_reset         (mem_reset),
        .mem_wr_en         (mem_wr_en),
        .mem_wr_data       (mem_wr_data),
        .mem_cmd_en        (mem_cmd_en),
        .mem_cmd_instr     (mem_cmd_instr),
        .mem_cmd_bl        (mem_cmd_bl),
        .mem_cmd_byte_addr (mem_cmd_byte_addr),
        .display_buf       (display_buf),
        .clear_frame       (clear_frame),
        .busy              (busy)
`ifdef FBW_STATS_EN
        ,
        .frame_count       (frame_count),
        .burst_count       (burst_count)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] words [0:4095];
    int          word_idx = 0;
    bit          chk_en = 1'b0;
    logic [29:0] cmd_addrs [$];

    // Model state: words committed to the frame, words in the open burst, buffers.
    int m_ptr, m_burst, m_frame_cnt, m_burst_cnt;
    bit m_active, m_disp, m_pend_fd, m_pend_rr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        bit          acc;
        logic [29:0] exp_addr;
        if (!reset_n) begin
            m_ptr = 0; m_burst = 0; m_frame_cnt = 0; m_burst_cnt = 0;
            m_active = 0; m_disp = 0; m_pend_fd = 0; m_pend_rr = 0;
        end else if (chk_en) begin
            acc = src_valid && src_ready;
            check("wr_en", mem_wr_en, acc);
            if (acc) check("wr_data", mem_wr_data, words[word_idx % 4096]);
            if (src_ready) begin
                check("ready_room", 32'((m_ptr + m_burst < FW) && (m_burst < BL)), 1);
                check("ready_wr_full", mem_wr_full, 0);
                check("ready_busy", busy, 1);
            end
            if (mem_cmd_en) begin
                exp_addr = (m_active ? B1 : B0) + 30'(m_ptr * 4);
                check("cmd_full", mem_cmd_full, 0);
                check("cmd_beats", m_burst, BL);
                check("cmd_bl", mem_cmd_bl, BL - 1);
                check("cmd_instr", mem_cmd_instr, 0);
                check("cmd_addr", mem_cmd_byte_addr, exp_addr);
                check("cmd_busy", busy, 1);
            end
            check("display_buf", display_buf, m_disp);
            check("clear_frame", clear_frame, 32'(m_ptr == 0));
`ifdef FBW_STATS_EN
            check("frame_count", frame_count, 32'(m_frame_cnt % 65536));
            check("burst_count", burst_count, 32'(m_burst_cnt % 16777216));
`endif
            if (acc) begin
                m_burst++;
                word_idx++;
            end
            if (mem_cmd_en) begin
                cmd_addrs.push_back(mem_cmd_byte_addr);
                m_ptr += BL;
                m_burst = 0;
                m_burst_cnt++;
            end
            m_pend_fd = m_pend_fd || frame_done;
            m_pend_rr = m_pend_rr || render_reset;
            if (!busy && (m_pend_fd || m_pend_rr)) begin
                if (m_pend_rr) begin
                    m_burst_cnt = 0;
                end else begin
                    m_disp   = m_active;
                    m_active = !m_active;
                    m_frame_cnt++;
                end
                m_ptr     = 0;
                m_pend_fd = 0;
                m_pend_rr = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        src_data     = words[word_idx % 4096];
        frame_done   = 1'b0;
        render_reset = 1'b0;
    endtask

    initial begin
        int n;
        int stall_idx;
        for (int i = 0; i < 4096; i++) words[i] = (i < 12) ? 32'hA0 + 32'(i) : $urandom;
        reset_n = 0; src_valid = 0; src_data = 0; frame_done = 0; render_reset = 0;
        mem_calib_done = 0; mem_wr_full = 0; mem_wr_empty = 1; mem_cmd_full = 0;
        repeat (3) tick();
        check("rst_mem_reset", mem_reset, 1);
        check("rst_busy", busy, 1);
        check("rst_src_ready", src_ready, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_cmd_en", mem_cmd_en, 0);
        check("rst_wr_data", mem_wr_data, 0);
        check("rst_cmd_bl", mem_cmd_bl, 0);
        check("rst_cmd_addr", mem_cmd_byte_addr, 0);
        check("rst_display", display_buf, 0);
        check("rst_clear", clear_frame, 1);

        // Calibration: calib rises after the 10th edge, IDLE by the 13th.
        reset_n = 1; src_valid = 1; chk_en = 1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            check("calib_busy", busy, 1);
            check("calib_no_ready", src_ready, 0);
            if (c == 1) check("calib_mem_reset", mem_reset, 0);
        end
        mem_calib_done = 1;
        tick(); check("sync_edge1_busy", busy, 1);
        tick(); check("sync_edge2_busy", busy, 1);
        tick(); check("idle_by_13", busy, 0);

        // Two bursts fill the 8-word frame, then intake stalls.
        for (int i = 0; i < 200 && !(cmd_addrs.size() >= 2); i++) tick();
        check("t_first_frame", 32'(cmd_addrs.size() >= 2), 1);
        repeat (6) tick();
        check("frame_stall_words", word_idx, 8);
        check("frame_stall_idle", busy, 0);
        check("cmd0_addr", cmd_addrs[0], B0);
        check("cmd1_addr", cmd_addrs[1], B0 + 30'd16);

        frame_done = 1;
        tick();
        tick();
        check("swap_display", display_buf, 0);
        check("swap_clear", clear_frame, 1);

        // Write-FIFO full for 3 cycles mid-burst, then cmd FIFO full for 2 CMD cycles.
        for (int i = 0; i < 100 && m_burst != 2; i++) tick();
        check("t_burst2", m_burst, 2);
        stall_idx = word_idx;
        mem_wr_full = 1;
        repeat (3) tick();
        check("no_accept_full", word_idx, stall_idx);
        mem_wr_full = 0;
        for (int i = 0; i < 100 && m_burst != 3; i++) tick();
        check("t_burst3", m_burst, 3);
        mem_cmd_full = 1;
        repeat (3) tick();
        check("cmd_waits", cmd_addrs.size(), 2);
        mem_cmd_full = 0;
        for (int i = 0; i < 100 && cmd_addrs.size() < 3; i++) tick();
        check("t_cmd2", cmd_addrs.size(), 3);
        check("cmd2_addr_buf1", cmd_addrs[2], B1);

        // frame_done and render_reset together during FILL.
        for (int i = 0; i < 100 && !(m_burst == 1 && busy); i++) tick();
        check("t_collide_fill", m_burst, 1);
        frame_done = 1; render_reset = 1;
        tick();
        for (int i = 0; i < 200 && cmd_addrs.size() < 5; i++) tick();
        check("t_collide_cmds", 32'(cmd_addrs.size() >= 5), 1);
        check("collide_inflight_addr", cmd_addrs[3], B1 + 30'd16);
        check("collide_restart_addr", cmd_addrs[4], B1);
        check("collide_display", display_buf, 0);
`ifdef FBW_STATS_EN
        check("collide_frame_count", frame_count, 1);
`endif

        for (int i = 0; i < 3000; i++) begin
            tick();
            src_valid    = $urandom_range(0, 3) != 0;
            mem_wr_full  = $urandom_range(0, 5) == 0;
            mem_cmd_full = $urandom_range(0, 3) == 0;
            mem_wr_empty = $urandom_range(0, 7) != 0;
            frame_done   = $urandom_range(0, 40) == 0;
            render_reset = $urandom_range(0, 150) == 0;
        end

        // Reset mid-burst: the open burst is dropped and no command goes out.
        src_valid = 1; mem_wr_full = 0; mem_cmd_full = 0; mem_wr_empty = 1;
        tick();
        frame_done = 1;
        tick();
        for (int i = 0; i < 200 && m_burst != 2; i++) tick();
        check("t_reset_burst", m_burst, 2);
        n = cmd_addrs.size();
        reset_n = 0;
        tick();
        check("reset_no_cmd_en", mem_cmd_en, 0);
        tick();
        check("reset_abandon", cmd_addrs.size(), n);
        reset_n = 1;
        for (int i = 0; i < 200 && cmd_addrs.size() <= n; i++) tick();
        check("t_after_reset_cmd", 32'(cmd_addrs.size() > n), 1);
        if (cmd_addrs.size() > n) check("after_reset_addr", cmd_addrs[n], B0);

        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
